// File: rtl/rand_pkg.sv
// Shared constants and types for the random-bit arbiter slice.
// The LFSR polynomial lives here so the generator and any model agree on taps.
package rand_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'h68F3;

  localparam int TAP0 = 0;
  localparam int TAP1 = 2;
  localparam int TAP2 = 3;
  localparam int TAP3 = 5;

  typedef enum logic {
    FILL,
    READY
  } arb_state_t;

  // Right-shifting Fibonacci step: the tap XOR re-enters at the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[TAP0] ^ q[TAP1] ^ q[TAP2] ^ q[TAP3], q[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; serial output is the LSB.
// Optional all-zero lockup recovery under RAND_ARB_LOCKUP_GUARD_EN.
module lfsr16
  import rand_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst,
  output logic q_out,
  output logic q_valid
);

  logic [LFSR_W-1:0] q;

`ifdef RAND_ARB_LOCKUP_GUARD_EN
  localparam logic [LFSR_W-1:0] RELOAD = (SEED == '0) ? 16'h0001 : SEED;

  logic lockup;
  assign lockup = (q == '0);

  // A stuck all-zero state is replaced by a known nonzero value; its bit is flagged unusable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (lockup) begin
      q <= RELOAD;
    end else begin
      q <= lfsr_next(q);
    end
  end

  assign q_valid = ~lockup;
`else
  if (SEED == '0) begin : g_seed_check
    $error("lfsr16: SEED of zero locks the LFSR without the lockup guard");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

  assign q_valid = 1'b1;
`endif

  assign q_out = q[0];

endmodule

// File: rtl/rand_req_arbiter.sv
// Builds WIDTH-bit words from a shared LFSR and hands each word to one requester, round-robin.
// Optional lockup guard in lfsr16 is enabled by defining RAND_ARB_LOCKUP_GUARD_EN.
module rand_req_arbiter
  import rand_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  ack,
  output logic [WIDTH-1:0] rand_val,
  output logic [IDW-1:0]   rand_id,
  output logic             busy
);

  if (NREQ < 2 || NREQ > 8) begin : g_nreq_check
    $error("rand_req_arbiter: NREQ must be 2..8");
  end
  if (WIDTH < 1 || WIDTH > 16) begin : g_width_check
    $error("rand_req_arbiter: WIDTH must be 1..16");
  end

  localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

  logic             q_bit;
  logic             q_valid;
  logic [WIDTH-1:0] acc;
  logic [4:0]       cnt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  arb_state_t       state;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .q_out  (q_bit),
    .q_valid(q_valid)
  );

  // First requesting index at or above ptr, wrapping around to the bottom.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
    logic [IDW-1:0] w;
    logic           found;
    int             idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!found && r[idx]) begin
        w     = IDW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign win = rr_pick(req, ptr);

  // Every READY->FILL transition discards the current LFSR bit, so no bit reaches two owners.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      acc      <= '0;
      cnt      <= '0;
      ptr      <= '0;
      ack      <= '0;
      rand_val <= '0;
      rand_id  <= '0;
      busy     <= 1'b1;
    end else begin
      ack <= '0;
      case (state)
        FILL: begin
          if (q_valid) begin
            acc <= WIDTH'({acc, q_bit});
            cnt <= cnt + 5'd1;
            if (cnt == CNT_LAST) begin
              state <= READY;
              busy  <= 1'b0;
            end
          end
        end
        READY: begin
          if (|req) begin
            ack      <= NREQ'(1) << win;
            rand_val <= acc;
            rand_id  <= win;
            ptr      <= (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
            cnt      <= '0;
            state    <= FILL;
            busy     <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_req_arbiter.sv
// Self-checking bench for rand_req_arbiter (default parameters, lockup guard off).
// A cycle model predicts each grant into a queue that the negedge monitor drains.
module tb_rand_req_arbiter;

  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam logic [15:0] SEED = 16'h68F3;

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  ack;
  logic [WIDTH-1:0] rand_val;
  logic [1:0]       rand_id;
  logic             busy;

  int total = 0;
  int bad = 0;
  int edges = 0;

  typedef struct packed {
    logic [NREQ-1:0]  ack;
    logic [WIDTH-1:0] val;
    logic [1:0]       id;
  } grant_t;

  grant_t exp_q[$];
  grant_t e;

  rand_req_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .SEED (SEED)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .rand_val(rand_val),
    .rand_id (rand_id),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edges = 0;
    else edges = edges + 1;
  end

  // Reference model: LFSR, word assembly and round-robin pointer.
  logic [15:0]      m_lfsr;
  logic [WIDTH-1:0] m_acc;
  int               m_cnt;
  bit               m_ready;
  int               m_ptr;
  int               m_w;
  bit               m_found;
  int               m_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr  = SEED;
      m_acc   = '0;
      m_cnt   = 0;
      m_ready = 0;
      m_ptr   = 0;
      exp_q.delete();
    end else begin
      if (!m_ready) begin
        m_acc = {m_acc[WIDTH-2:0], m_lfsr[0]};
        m_cnt = m_cnt + 1;
        if (m_cnt == WIDTH) m_ready = 1;
      end else if (req != 0) begin
        m_found = 0;
        m_w = 0;
        for (int k = 0; k < NREQ; k++) begin
          m_idx = (m_ptr + k) % NREQ;
          if (!m_found && req[m_idx]) begin
            m_w = m_idx;
            m_found = 1;
          end
        end
        exp_q.push_back({4'(1 << m_w), m_acc, 2'(m_w)});
        m_ptr = (m_w + 1) % NREQ;
        m_cnt = 0;
        m_ready = 0;
      end
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  end

  always @(negedge clk) begin
    if (!rst && (ack != 0 || exp_q.size() != 0)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_unexpected: ack=%b expected no grant", ack);
      end else begin
        e = exp_q.pop_front();
        if (ack !== e.ack || rand_val !== e.val || rand_id !== e.id) begin
          bad++;
          $display("[TB] FAIL sb_grant: got ack=%b val=%h id=%0d expected ack=%b val=%h id=%0d",
                   ack, rand_val, rand_id, e.ack, e.val, e.id);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [NREQ-1:0] r);
    @(negedge clk);
    rst = 1'b1;
    req = r;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (ack != 0) found = 1;
    end
  endtask

  task automatic test_reset();
    req = '0;
    rst = 1'b1;
    #1;
    total++;
    if (ack !== 4'b0000 || rand_val !== 8'h00 || rand_id !== 2'd0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_values: got ack=%b val=%h id=%0d busy=%b expected 0000/00/0/1",
               ack, rand_val, rand_id, busy);
    end
  endtask

  task automatic test_single();
    bit found;
    applyStimulus(4'b0001);
    wait_ack(30, found);
    total++;
    if (!found || edges != 9 || rand_val !== 8'hCF || rand_id !== 2'd0) begin
      bad++;
      $display("[TB] FAIL first_grant: got found=%0d edge=%0d val=%h id=%0d expected 1/9/cf/0",
               found, edges, rand_val, rand_id);
    end
    wait_ack(30, found);
    total++;
    if (!found || edges != 18 || rand_val !== 8'h2C || ack !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL second_grant: got found=%0d edge=%0d val=%h ack=%b expected 1/18/2c/0001",
               found, edges, rand_val, ack);
    end
  endtask

  task automatic test_all_requesters();
    bit found;
    int last_edge;
    int ids[5] = '{0, 1, 2, 3, 0};
    applyStimulus(4'b1111);
    last_edge = 0;
    for (int n = 0; n < 5; n++) begin
      wait_ack(30, found);
      total++;
      if (!found || rand_id !== 2'(ids[n]) || !$onehot(ack) || edges - last_edge != 9) begin
        bad++;
        $display("[TB] FAIL rr_cycle%0d: got found=%0d id=%0d ack=%b gap=%0d expected id=%0d onehot gap=9",
                 n, found, rand_id, ack, edges - last_edge, ids[n]);
      end
      last_edge = edges;
    end
  endtask

  task automatic test_idle_hold();
    bit stray;
    applyStimulus(4'b0000);
    stray = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ack != 0) stray = 1;
      if (edges == 7) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL busy_edge7: got %b expected 1", busy);
        end
      end
      if (edges == 8) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("[TB] FAIL busy_edge8: got %b expected 0", busy);
        end
      end
    end
    total++;
    if (busy !== 1'b0 || stray) begin
      bad++;
      $display("[TB] FAIL idle_hold: got busy=%b stray_ack=%0d expected 0/0", busy, stray);
    end
    req = 4'b0100;
    @(negedge clk);
    total++;
    if (ack !== 4'b0100 || rand_val !== 8'hCF || rand_id !== 2'd2) begin
      bad++;
      $display("[TB] FAIL frozen_grant: got ack=%b val=%h id=%0d expected 0100/cf/2", ack, rand_val, rand_id);
    end
    req = 4'b0000;
  endtask

  task automatic test_mid_reset();
    bit found;
    applyStimulus(4'b0001);
    wait_ack(30, found);
    while (edges < 14) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (ack !== 4'b0000 || rand_val !== 8'h00 || rand_id !== 2'd0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_reset: got ack=%b val=%h id=%0d busy=%b expected 0000/00/0/1",
               ack, rand_val, rand_id, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_ack(30, found);
    total++;
    if (!found || edges != 9 || rand_val !== 8'hCF) begin
      bad++;
      $display("[TB] FAIL restart_grant: got found=%0d edge=%0d val=%h expected 1/9/cf", found, edges, rand_val);
    end
  endtask

  task automatic checkOutput();
    bit found;
    applyStimulus(4'b0010);
    wait_ack(30, found);
    req = 4'b1010;
    wait_ack(30, found);
    total++;
    if (!found || rand_id !== 2'd3 || ack !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL rr_ptr2: got found=%0d id=%0d ack=%b expected 1/3/1000", found, rand_id, ack);
    end
    wait_ack(30, found);
    total++;
    if (!found || rand_id !== 2'd1 || ack !== 4'b0010) begin
      bad++;
      $display("[TB] FAIL rr_wrap: got found=%0d id=%0d ack=%b expected 1/1/0010", found, rand_id, ack);
    end
    wait_ack(30, found);
    req = 4'b1000;
    wait_ack(30, found);
    total++;
    if (!found || rand_id !== 2'd3 || ack[1] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL withdraw: got found=%0d id=%0d ack=%b expected 1/3/no ack1", found, rand_id, ack);
    end
    req = 4'b0011;
    wait_ack(30, found);
    total++;
    if (!found || rand_id !== 2'd0 || ack !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL ptr_zero: got found=%0d id=%0d ack=%b expected 1/0/0001", found, rand_id, ack);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    test_reset();
    test_single();
    test_all_requesters();
    test_idle_hold();
    test_mid_reset();
    checkOutput();
    applyStimulus(4'b0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
